// File: rtl/ingress_voq.sv
// ---------------------------------------------------------------------------
// ingress_voq
//
// Purpose
//   Ingress side of a switch port. The host interface writes metadata words,
//   and each word goes into a virtual output queue (VOQ) chosen by its
//   destination field. All VOQs live in one shared simple dual-port memory,
//   and each VOQ owns a contiguous region of VOQ_DEPTH entries in it.
//   Per-VOQ occupancy is exposed to the scheduler. A scheduler grant pops the
//   head of the chosen VOQ toward the crossbar.
//
// Parameters
//   PORT_NUM   : number of destination ports / VOQs (power of 2, >= 2)
//   VOQ_DEPTH  : entries per VOQ (power of 2)
//   META_WIDTH : metadata word width. The destination is taken from the top
//                $clog2(PORT_NUM) bits of the word.
//
// Ports
//   clk            in   clock
//   reset          in   asynchronous, active-high reset
//   ingress_in     in   metadata word from the interface
//   ingress_in_en  in   write strobe, one word per cycle
//   sched_sel      in   VOQ granted by the scheduler
//   sched_en       in   grant strobe: pop the head of VOQ sched_sel
//   voq_empty      out  bit p = VOQ p empty
//   voq_full       out  bit p = VOQ p full
//   ingress_out    out  popped metadata word (holds when ingress_out_en=0)
//   ingress_out_en out  one-cycle valid pulse per pop
//   drop_cnt       out  dropped-write counter
//
// Build options
//   INGRESS_DROP_CNT_EN : when defined, drop_cnt counts dropped writes and
//                         saturates at 16'hFFFF. When undefined, drop_cnt is
//                         tied to 0. Drop behaviour is the same either way.
// ---------------------------------------------------------------------------
module ingress_voq #(
    parameter int PORT_NUM   = 4,
    parameter int VOQ_DEPTH  = 256,
    parameter int META_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [META_WIDTH-1:0]       ingress_in,
    input  logic                        ingress_in_en,
    input  logic [$clog2(PORT_NUM)-1:0] sched_sel,
    input  logic                        sched_en,
    output logic [PORT_NUM-1:0]         voq_empty,
    output logic [PORT_NUM-1:0]         voq_full,
    output logic [META_WIDTH-1:0]       ingress_out,
    output logic                        ingress_out_en,
    output logic [15:0]                 drop_cnt
);

    localparam int PW       = $clog2(PORT_NUM);
    localparam int IW       = $clog2(VOQ_DEPTH);
    localparam int CW       = IW + 1;
    localparam int AW       = PW + IW;
    localparam int MEM_SIZE = PORT_NUM * VOQ_DEPTH;

    localparam logic [CW-1:0] FULL_COUNT = CW'(VOQ_DEPTH);

    // Per-VOQ state, gathered into arrays so that the shared datapath can
    // index it by destination or by grant.
    logic [IW-1:0] voq_start [PORT_NUM];
    logic [IW-1:0] voq_end   [PORT_NUM];
    logic [CW-1:0] voq_count [PORT_NUM];

    logic [META_WIDTH-1:0] mem [MEM_SIZE];

    logic [PW-1:0]         dest;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [AW-1:0]         wr_addr;
    logic [AW-1:0]         rd_addr;

    logic [META_WIDTH-1:0] rd_data_reg;
    logic                  out_en_reg;
    logic                  has_data_reg;

    // Both decisions use the count from before this cycle. A write to a full
    // VOQ is dropped even if the same VOQ is popped in this cycle. A pop of an
    // empty VOQ is ignored even if the same VOQ is written in this cycle.
    assign dest      = ingress_in[META_WIDTH-1 -: PW];
    assign wr_accept = ingress_in_en && (voq_count[dest] != FULL_COUNT);
    assign rd_accept = sched_en && (voq_count[sched_sel] != '0);
    assign wr_addr   = {dest, voq_end[dest]};
    assign rd_addr   = {sched_sel, voq_start[sched_sel]};

    // -----------------------------------------------------------------------
    // Per-VOQ pointers and occupancy
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_voq
            logic [IW-1:0] start_reg;
            logic [IW-1:0] end_reg;
            logic [CW-1:0] count_reg;
            logic          wr_hit;
            logic          rd_hit;

            assign wr_hit = wr_accept && (dest == PW'(gi));
            assign rd_hit = rd_accept && (sched_sel == PW'(gi));

            // The pointers are IW bits wide and VOQ_DEPTH is a power of two,
            // so the natural overflow gives the wrap from VOQ_DEPTH-1 to 0.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    start_reg <= '0;
                    end_reg   <= '0;
                    count_reg <= '0;
                end else begin
                    if (wr_hit) begin
                        end_reg <= end_reg + IW'(1);
                    end
                    if (rd_hit) begin
                        start_reg <= start_reg + IW'(1);
                    end
                    // A write and a pop on the same VOQ cancel out in the count.
                    if (wr_hit && !rd_hit) begin
                        count_reg <= count_reg + CW'(1);
                    end else if (rd_hit && !wr_hit) begin
                        count_reg <= count_reg - CW'(1);
                    end
                end
            end

            assign voq_start[gi] = start_reg;
            assign voq_end[gi]   = end_reg;
            assign voq_count[gi] = count_reg;

            // These flags are decoded from the registered count, so they show
            // the state after the updates of the last clock edge.
            assign voq_empty[gi] = (count_reg == '0);
            assign voq_full[gi]  = (count_reg == FULL_COUNT);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Shared memory: one write port and one registered read port. There is no
    // reset here, so the tools can map the array onto block RAM. An accepted
    // pop reads a valid entry and an accepted write targets a free one, so
    // the two addresses never collide in the same cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_addr] <= ingress_in;
        end
        if (rd_accept) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    // The read register has no reset. has_data_reg forces the visible output
    // to zero from reset until the first pop, and ingress_out then holds the
    // last popped word between pops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_en_reg   <= 1'b0;
            has_data_reg <= 1'b0;
        end else begin
            out_en_reg   <= rd_accept;
            has_data_reg <= has_data_reg | rd_accept;
        end
    end

    assign ingress_out_en = out_en_reg;
    assign ingress_out    = has_data_reg ? rd_data_reg : '0;

    // -----------------------------------------------------------------------
    // Dropped-write counter
    // -----------------------------------------------------------------------
`ifdef INGRESS_DROP_CNT_EN
    logic [15:0] drop_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_reg <= '0;
        end else if (ingress_in_en && !wr_accept && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ingress_voq.sv
// ---------------------------------------------------------------------------
// tb_ingress_voq
//
// Purpose
//   Self-checking bench for ingress_voq with its default parameters
//   (4 VOQs, 256 entries each, 32-bit words).
//
//   The reference model keeps one queue per destination and one drop count.
//   A compare process checks every DUT output against this model on each
//   falling clock edge. Directed checks with literal expectations are added
//   for the cases that the model itself depends on.
//
//   Define INGRESS_DROP_CNT_EN for both the bench and the RTL to check the
//   counting build.
// ---------------------------------------------------------------------------
module tb_ingress_voq;

    localparam int D = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ingress_in = '0;
    logic        ingress_in_en = 1'b0;
    logic [1:0]  sched_sel = '0;
    logic        sched_en = 1'b0;
    logic [3:0]  voq_empty;
    logic [3:0]  voq_full;
    logic [31:0] ingress_out;
    logic        ingress_out_en;
    logic [15:0] drop_cnt;

    ingress_voq #(
        .PORT_NUM   (4),
        .VOQ_DEPTH  (D),
        .META_WIDTH (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ingress_in     (ingress_in),
        .ingress_in_en  (ingress_in_en),
        .sched_sel      (sched_sel),
        .sched_en       (sched_en),
        .voq_empty      (voq_empty),
        .voq_full       (voq_full),
        .ingress_out    (ingress_out),
        .ingress_out_en (ingress_out_en),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] q [4][$];
    logic [31:0] exp_out = '0;
    logic        exp_en = 1'b0;
    int          exp_drop = 0;
    bit          cmp_on = 1'b0;

`ifdef INGRESS_DROP_CNT_EN
    localparam bit DROP_ON = 1'b1;
`else
    localparam bit DROP_ON = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 4; p++) q[p].delete();
        exp_out  = '0;
        exp_en   = 1'b0;
        exp_drop = 0;
    endtask

    // Applies the rules to one cycle. Both acceptance decisions use the
    // occupancy from before the cycle.
    task automatic model_step(input bit wen, input logic [31:0] wd, input bit sen, input logic [1:0] ss);
        int  d;
        bit  wacc;
        bit  racc;
        d    = int'(wd[31:30]);
        wacc = wen && (q[d].size() < D);
        racc = sen && (q[int'(ss)].size() != 0);
        exp_en = racc;
        if (racc) exp_out = q[int'(ss)].pop_front();
        if (wacc) q[d].push_back(wd);
        if (wen && !wacc && DROP_ON && exp_drop < 65535) exp_drop++;
    endtask

    // One clock: apply the inputs, let the DUT sample them on the rising
    // edge, update the model, and return at the falling edge.
    task automatic cycle(input bit wen, input logic [31:0] wd, input bit sen, input logic [1:0] ss);
        ingress_in    = wd;
        ingress_in_en = wen;
        sched_en      = sen;
        sched_sel     = ss;
        @(posedge clk);
        model_step(wen, wd, sen, ss);
        @(negedge clk);
        ingress_in_en = 1'b0;
        sched_en      = 1'b0;
    endtask

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            logic [3:0] e_empty;
            logic [3:0] e_full;
            for (int p = 0; p < 4; p++) begin
                e_empty[p] = (q[p].size() == 0);
                e_full[p]  = (q[p].size() == D);
            end
            chk("voq_empty", 64'(voq_empty), 64'(e_empty));
            chk("voq_full", 64'(voq_full), 64'(e_full));
            chk("ingress_out_en", 64'(ingress_out_en), 64'(exp_en));
            chk("ingress_out", 64'(ingress_out), 64'(exp_out));
            chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        end
    end

    initial begin
        logic [1:0]  pp;
        logic [1:0]  dd;
        logic [31:0] w;

        model_reset();
        repeat (3) @(negedge clk);

        // Test 1: reset values
        chk("t1_empty", 64'(voq_empty), 64'h0F);
        chk("t1_full", 64'(voq_full), 64'h0);
        chk("t1_out_en", 64'(ingress_out_en), 64'h0);
        chk("t1_out", 64'(ingress_out), 64'h0);
        chk("t1_drop", 64'(drop_cnt), 64'h0);
        reset  = 1'b0;
        cmp_on = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 2'd0);

        // Test 2: single word through VOQ 1
        cycle(1'b1, 32'h4000_0011, 1'b0, 2'd0);
        chk("t2_empty1_after_write", 64'(voq_empty[1]), 64'h0);
        cycle(1'b0, 32'h0, 1'b1, 2'd1);
        chk("t2_out", 64'(ingress_out), 64'h4000_0011);
        chk("t2_out_en", 64'(ingress_out_en), 64'h1);
        chk("t2_empty1_after_pop", 64'(voq_empty[1]), 64'h1);
        cycle(1'b0, 32'h0, 1'b0, 2'd0);
        chk("t2_out_en_pulse", 64'(ingress_out_en), 64'h0);
        chk("t2_out_hold", 64'(ingress_out), 64'h4000_0011);

        // Test 3: 257 writes to VOQ 2, then drain it
        for (int i = 0; i < 257; i++) begin
            cycle(1'b1, {2'b10, 30'(i)}, 1'b0, 2'd0);
            if (i == 254) chk("t3_not_full_255", 64'(voq_full[2]), 64'h0);
            if (i == 255) chk("t3_full_256", 64'(voq_full[2]), 64'h1);
        end
        chk("t3_drop", 64'(drop_cnt), DROP_ON ? 64'h1 : 64'h0);
        for (int i = 0; i < 256; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 2'd2);
            chk("t3_pop_data", 64'(ingress_out), 64'({2'b10, 30'(i)}));
        end
        chk("t3_empty2", 64'(voq_empty[2]), 64'h1);

        // Test 4: a grant on empty VOQ 3 is ignored
        cycle(1'b0, 32'h0, 1'b1, 2'd3);
        chk("t4_out_en", 64'(ingress_out_en), 64'h0);
        chk("t4_empty3", 64'(voq_empty[3]), 64'h1);
        cycle(1'b1, 32'hC000_0ABC, 1'b0, 2'd0);
        cycle(1'b0, 32'h0, 1'b1, 2'd3);
        chk("t4_first_word", 64'(ingress_out), 64'hC000_0ABC);

        // Test 5: VOQ 0 full, then a write and a pop in the same cycle
        for (int i = 0; i < 256; i++) cycle(1'b1, 32'(i + 32'h100), 1'b0, 2'd0);
        chk("t5_full0", 64'(voq_full[0]), 64'h1);
        cycle(1'b1, 32'h0BAD_BEEF, 1'b1, 2'd0);
        chk("t5_out_en", 64'(ingress_out_en), 64'h1);
        chk("t5_out", 64'(ingress_out), 64'h0000_0100);
        chk("t5_full0_after", 64'(voq_full[0]), 64'h0);
        chk("t5_drop", 64'(drop_cnt), DROP_ON ? 64'h2 : 64'h0);
        for (int i = 0; i < 255; i++) cycle(1'b0, 32'h0, 1'b1, 2'd0);
        chk("t5_last_word", 64'(ingress_out), 64'h0000_01FF);
        chk("t5_empty0", 64'(voq_empty[0]), 64'h1);

        // Move each VOQ's pointers 200 entries forward so the traffic below
        // wraps them. A write and a pop on the same non-empty VOQ share a cycle.
        for (int p = 0; p < 4; p++) begin
            pp = 2'(p);
            for (int i = 0; i < 200; i++) cycle(1'b1, {pp, 30'(i + 32'h2000)}, i > 0, pp);
            cycle(1'b0, 32'h0, 1'b1, pp);
        end

        // Test 6: writes and round-robin pops over 600 cycles, then drain
        for (int i = 0; i < 600; i++) begin
            dd = 2'((i + i / 8) % 4);
            w  = {dd, 30'(i + 32'h5000)};
            cycle((i % 7) != 6, w, (i % 5) != 4, 2'(i % 4));
        end
        for (int i = 0; i < 400; i++) cycle(1'b0, 32'h0, 1'b1, 2'(i % 4));
        chk("t6_all_empty", 64'(voq_empty), 64'h0F);

`ifdef INGRESS_DROP_CNT_EN
        // The drop counter must saturate at 16'hFFFF
        for (int i = 0; i < 256; i++) cycle(1'b1, 32'(32'hC000_0000 + i), 1'b0, 2'd0);
        for (int i = 0; i < 65540; i++) cycle(1'b1, 32'hC000_FFFF, 1'b0, 2'd0);
        chk("t6_drop_saturated", 64'(drop_cnt), 64'hFFFF);
`endif

        // Reset during a pop: no valid pulse may follow
        cycle(1'b1, 32'h4000_0077, 1'b0, 2'd0);
        sched_sel = 2'd1;
        sched_en  = 1'b1;
        @(posedge clk);
        cmp_on = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("t7_out_en_reset", 64'(ingress_out_en), 64'h0);
        chk("t7_empty_reset", 64'(voq_empty), 64'h0F);
        chk("t7_out_reset", 64'(ingress_out), 64'h0);
        @(negedge clk);
        sched_en = 1'b0;
        reset    = 1'b0;
        model_reset();
        cmp_on   = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 2'd0);
        chk("t7_no_pulse_after", 64'(ingress_out_en), 64'h0);
        cycle(1'b0, 32'h0, 1'b0, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
